// File: rtl/ha_chk_pkg.sv
// ============================================================================
// Module : ha_chk_pkg
// Brief  : Shared types and golden half-adder model for the response checker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ha_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    localparam int c_LATENCY_MAX = 15;

    // One lane of the golden model, packed as {ca, s}.
    function automatic logic [1:0] ha_model(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    function automatic bit latency_ok(input int lat);
        return (lat >= 0) && (lat <= c_LATENCY_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ha_chk_delay.sv
// ============================================================================
// Module : ha_chk_delay
// Brief  : LATENCY-stage {valid,a,b} shift register with sync flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ha_chk_delay #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             any_valid
);

    generate
        if (LATENCY == 0) begin : g_wire
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, rst_n, flush};
            assign out_valid   = in_valid;
            assign out_a       = in_a;
            assign out_b       = in_b;
            assign any_valid   = 1'b0;
        end else begin : g_shift
            logic [LATENCY-1:0] r_vld;
            logic [WIDTH-1:0]   r_a [LATENCY];
            logic [WIDTH-1:0]   r_b [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        r_a[i] <= '0;
                        r_b[i] <= '0;
                    end
                end else begin
                    r_vld[0] <= in_valid & ~flush;
                    r_a[0]   <= in_a;
                    r_b[0]   <= in_b;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_vld[i] <= r_vld[i-1] & ~flush;
                        r_a[i]   <= r_a[i-1];
                        r_b[i]   <= r_b[i-1];
                    end
                end
            end

            assign out_valid = r_vld[LATENCY-1];
            assign out_a     = r_a[LATENCY-1];
            assign out_b     = r_b[LATENCY-1];
            assign any_valid = |r_vld;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/ha_resp_checker.sv
// ============================================================================
// Module : ha_resp_checker
// Brief  : Checks delayed DUT s/ca against a golden half adder; keeps stats.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ha_resp_checker
    import ha_chk_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] ca,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [WIDTH-1:0] first_s,
    output logic [WIDTH-1:0] first_ca
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    generate
        if (!latency_ok(LATENCY)) begin : g_bad_latency
            $error("ha_resp_checker: LATENCY must be in 0..15");
        end
    endgenerate

    chk_state_t       r_state, w_state_nxt;
    logic             w_flush, w_push, w_dv, w_any, w_mis;
    logic [WIDTH-1:0] w_da, w_db, w_exp_s, w_exp_ca;

    logic             r_err;
    logic [CNT_W-1:0] r_chk, r_errc, r_fidx;
    logic [WIDTH-1:0] r_fa, r_fb, r_fs, r_fca;

    assign w_push = in_valid && (r_state == RUN);

    ha_chk_delay #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_flush),
        .in_valid  (w_push),
        .in_a      (a),
        .in_b      (b),
        .out_valid (w_dv),
        .out_a     (w_da),
        .out_b     (w_db),
        .any_valid (w_any)
    );

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            assign {w_exp_ca[i], w_exp_s[i]} = ha_model(w_da[i], w_db[i]);
        end
    endgenerate

    // Any lane differing makes the whole result one mismatch.
    assign w_mis = |((s ^ w_exp_s) | (ca ^ w_exp_ca));

    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_flush     = 1'b1;
                end
            end
            RUN:     if (stop)   w_state_nxt = DRAIN;
            DRAIN:   if (!w_any) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_chk   <= '0;
            r_errc  <= '0;
            r_fidx  <= '0;
            r_fa    <= '0;
            r_fb    <= '0;
            r_fs    <= '0;
            r_fca   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush) begin
                r_err  <= 1'b0;
                r_chk  <= '0;
                r_errc <= '0;
                r_fidx <= '0;
                r_fa   <= '0;
                r_fb   <= '0;
                r_fs   <= '0;
                r_fca  <= '0;
            end else if (w_dv) begin
                if (r_chk != c_CNT_MAX) r_chk <= r_chk + c_CNT_ONE;
                if (w_mis) begin
                    if (r_errc != c_CNT_MAX) r_errc <= r_errc + c_CNT_ONE;
                    r_err <= 1'b1;
                    if (!r_err) begin
                        r_fidx <= r_chk;
                        r_fa   <= w_da;
                        r_fb   <= w_db;
                        r_fs   <= s;
                        r_fca  <= ca;
                    end
                end
            end
        end
    end

    assign busy      = (r_state == RUN) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign err       = r_err;
    assign chk_cnt   = r_chk;
    assign err_cnt   = r_errc;
    assign first_idx = r_fidx;
    assign first_a   = r_fa;
    assign first_b   = r_fb;
    assign first_s   = r_fs;
    assign first_ca  = r_fca;

endmodule

`default_nettype wire
